// File: rtl/merger_stream_pkg.sv
// merger_stream shared types: FSM encoding, terminator word, ordering rule.
// Words are widened to MAX_W so one function serves every DATA_W.
package merger_stream_pkg;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_1 = 2'd1,
    DRAIN_2 = 2'd2
  } state_e;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  localparam word_t ZERO_WORD = '0;

  function automatic logic precedes(
    word_t a,
    word_t b,
    logic  desc
  );
    return desc ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/merger_stream_if.sv
// merger_stream bus: two show-ahead upstream heads plus the merged output.
// master is the merger side, slave the surrounding logic.
interface merger_stream_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  logic [DATA_W-1:0] i_fifo_1;
  logic              i_fifo_1_empty;
  logic              o_fifo_1_read;
  logic [DATA_W-1:0] i_fifo_2;
  logic              i_fifo_2_empty;
  logic              o_fifo_2_read;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_out_ready;
  logic [CNT_W-1:0]  o_run_cnt;
  logic              o_err_order;

  modport master (
    input  i_fifo_1, i_fifo_1_empty,
    input  i_fifo_2, i_fifo_2_empty,
    input  i_out_ready,
    output o_fifo_1_read, o_fifo_2_read,
    output o_data, o_valid,
    output o_run_cnt, o_err_order
  );

  modport slave (
    output i_fifo_1, i_fifo_1_empty,
    output i_fifo_2, i_fifo_2_empty,
    output i_out_ready,
    input  o_fifo_1_read, o_fifo_2_read,
    input  o_data, o_valid,
    input  o_run_cnt, o_err_order
  );

endinterface

// File: rtl/merger_stream_sync_fifo_fwft.sv
// Show-ahead synchronous FIFO; a push while full is taken
// when a pop frees the slot in the same cycle.
module sync_fifo_fwft #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     cnt;
  logic              wr_en;
  logic              rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/merger_stream.sv
// Two-way sorted-run merger with drain states, run counter
// and sticky input order check, buffered by an output FIFO.
module merger_stream #(
  parameter int DATA_W     = 32,
  parameter int OUT_DEPTH  = 8,
  parameter int DESCENDING = 0,
  parameter int CNT_W      = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  merger_stream_if.master bus
);

  import merger_stream_pkg::*;

  localparam logic DESC = (DESCENDING != 0);

  typedef logic [DATA_W-1:0] data_t;

  state_e           state;
  state_e           nxt;
  logic             go;
  data_t            last_1;
  data_t            last_2;
  logic [CNT_W-1:0] run_cnt;
  logic             err;

  data_t a;
  data_t b;
  logic  az;
  logic  bz;
  logic  e1;
  logic  e2;
  logic  rd_1;
  logic  rd_2;
  logic  push;
  logic  inc;
  data_t wdata;
  logic  full;
  logic  empty;
  logic  pop_out;
  logic  can_wr;

  assign a       = bus.i_fifo_1;
  assign b       = bus.i_fifo_2;
  assign e1      = bus.i_fifo_1_empty;
  assign e2      = bus.i_fifo_2_empty;
  assign az      = (word_t'(a) == ZERO_WORD);
  assign bz      = (word_t'(b) == ZERO_WORD);
  assign pop_out = ~empty & bus.i_out_ready;
  assign can_wr  = ~full | pop_out;

  always_comb begin
    rd_1  = 1'b0;
    rd_2  = 1'b0;
    push  = 1'b0;
    inc   = 1'b0;
    wdata = a;
    nxt   = state;
    if (go && can_wr) begin
      unique case (state)
        MERGE: if (!e1 && !e2) begin
          push = 1'b1;
          unique case (1'b1)
            az && bz: begin
              rd_1  = 1'b1;
              rd_2  = 1'b1;
              wdata = '0;
              inc   = 1'b1;
            end
            az && !bz: begin
              rd_2  = 1'b1;
              wdata = b;
              nxt   = DRAIN_2;
            end
            !az && bz: begin
              rd_1 = 1'b1;
              nxt  = DRAIN_1;
            end
            default: begin
              if (precedes(word_t'(a), word_t'(b), DESC)) begin
                rd_1 = 1'b1;
              end else begin
                rd_2  = 1'b1;
                wdata = b;
              end
            end
          endcase
        end
        // parked channel head is its sentinel, popped with ours
        DRAIN_1: if (!e1) begin
          rd_1 = 1'b1;
          push = 1'b1;
          if (az) begin
            rd_2 = 1'b1;
            inc  = 1'b1;
            nxt  = MERGE;
          end
        end
        DRAIN_2: if (!e2) begin
          rd_2  = 1'b1;
          push  = 1'b1;
          wdata = b;
          if (bz) begin
            rd_1 = 1'b1;
            inc  = 1'b1;
            nxt  = MERGE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= MERGE;
      go      <= 1'b0;
      last_1  <= '0;
      last_2  <= '0;
      run_cnt <= '0;
      err     <= 1'b0;
    end else begin
      go    <= 1'b1;
      state <= nxt;
      if (inc) run_cnt <= run_cnt + CNT_W'(1);
      if (rd_1) begin
        if (az) begin
          last_1 <= '0;
        end else begin
          if (last_1 != '0 &&
              !precedes(word_t'(last_1), word_t'(a), DESC))
            err <= 1'b1;
          last_1 <= a;
        end
      end
      if (rd_2) begin
        if (bz) begin
          last_2 <= '0;
        end else begin
          if (last_2 != '0 &&
              !precedes(word_t'(last_2), word_t'(b), DESC))
            err <= 1'b1;
          last_2 <= b;
        end
      end
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop_out),
    .rdata (bus.o_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.o_valid       = ~empty;
  assign bus.o_fifo_1_read = rd_1;
  assign bus.o_fifo_2_read = rd_2;
  assign bus.o_run_cnt     = run_cnt;
  assign bus.o_err_order   = err;

endmodule

// File: tb/tb_merger_stream.sv
// merger_stream bench: ascending (depth 4) and descending (depth 8)
// instances driven from queues and checked against a list-merge model.
module tb_merger_stream;

  localparam int DW = 16;
  localparam int CW = 4;

  typedef logic [DW-1:0] w_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  merger_stream_if #(.DATA_W(DW), .CNT_W(CW)) bus_a ();
  merger_stream_if #(.DATA_W(DW), .CNT_W(CW)) bus_d ();

  merger_stream #(
    .DATA_W(DW), .OUT_DEPTH(4), .DESCENDING(0), .CNT_W(CW)
  ) u_asc (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a)
  );

  merger_stream #(
    .DATA_W(DW), .OUT_DEPTH(8), .DESCENDING(1), .CNT_W(CW)
  ) u_dsc (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_d)
  );

  w_t          h1 [2];
  w_t          h2 [2];
  logic        e1 [2];
  logic        e2 [2];
  logic        rdy [2];
  logic        r1 [2];
  logic        r2 [2];
  logic        vld [2];
  w_t          dat [2];
  logic [CW-1:0] cnt [2];
  logic        err [2];

  assign bus_a.i_fifo_1       = h1[0];
  assign bus_a.i_fifo_1_empty = e1[0];
  assign bus_a.i_fifo_2       = h2[0];
  assign bus_a.i_fifo_2_empty = e2[0];
  assign bus_a.i_out_ready    = rdy[0];
  assign bus_d.i_fifo_1       = h1[1];
  assign bus_d.i_fifo_1_empty = e1[1];
  assign bus_d.i_fifo_2       = h2[1];
  assign bus_d.i_fifo_2_empty = e2[1];
  assign bus_d.i_out_ready    = rdy[1];

  assign r1[0]  = bus_a.o_fifo_1_read;
  assign r2[0]  = bus_a.o_fifo_2_read;
  assign vld[0] = bus_a.o_valid;
  assign dat[0] = bus_a.o_data;
  assign cnt[0] = bus_a.o_run_cnt;
  assign err[0] = bus_a.o_err_order;
  assign r1[1]  = bus_d.o_fifo_1_read;
  assign r2[1]  = bus_d.o_fifo_2_read;
  assign vld[1] = bus_d.o_valid;
  assign dat[1] = bus_d.o_data;
  assign cnt[1] = bus_d.o_run_cnt;
  assign err[1] = bus_d.o_err_order;

  w_t   pend1 [2][$];
  w_t   pend2 [2][$];
  w_t   q1 [2][$];
  w_t   q2 [2][$];
  w_t   exp_q [2][$];
  w_t   ra [$];
  w_t   rb [$];
  int   src_q [$];
  int   exp_runs [2];
  logic exp_err [2];

  logic c1 [2];
  logic c2 [2];
  logic s_err [2];
  int   first_rd [2];
  int   first_val [2];
  int   last_val [2];
  int   val_n [2];
  int   n_pops [2];

  int n_chk = 0;
  int n_fail = 0;
  int stall_pct = 0;
  int bp_pct = 0;
  int cyc = 0;

  task automatic chk(string tag, int got, int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic prec(w_t x, w_t y, logic desc);
    return desc ? (x >= y) : (x <= y);
  endfunction

  // Expected output of one run pair is the stable two-list merge then a 0.
  task automatic add_pair(int d);
    logic desc;
    int   i;
    int   j;
    desc = (d == 1);
    i = 0;
    j = 0;
    foreach (ra[k]) pend1[d].push_back(ra[k]);
    foreach (rb[k]) pend2[d].push_back(rb[k]);
    pend1[d].push_back('0);
    pend2[d].push_back('0);
    while (i < ra.size() && j < rb.size()) begin
      if (prec(ra[i], rb[j], desc)) begin
        exp_q[d].push_back(ra[i]);
        i++;
      end else begin
        exp_q[d].push_back(rb[j]);
        j++;
      end
    end
    while (i < ra.size()) begin
      exp_q[d].push_back(ra[i]);
      i++;
    end
    while (j < rb.size()) begin
      exp_q[d].push_back(rb[j]);
      j++;
    end
    exp_q[d].push_back('0);
    exp_runs[d]++;
    for (int k = 1; k < ra.size(); k++)
      if (!prec(ra[k-1], ra[k], desc)) exp_err[d] = 1'b1;
    for (int k = 1; k < rb.size(); k++)
      if (!prec(rb[k-1], rb[k], desc)) exp_err[d] = 1'b1;
  endtask

  task automatic rand_runs(logic desc);
    int n;
    ra.delete();
    rb.delete();
    n = $urandom_range(0, 5);
    repeat (n) ra.push_back(w_t'($urandom_range(1, 30)));
    n = $urandom_range(0, 5);
    repeat (n) rb.push_back(w_t'($urandom_range(1, 30)));
    if (desc) begin
      ra.rsort();
      rb.rsort();
    end else begin
      ra.sort();
      rb.sort();
    end
  endtask

  task automatic clear_trk();
    for (int d = 0; d < 2; d++) begin
      first_rd[d]  = -1;
      first_val[d] = -1;
      last_val[d]  = -1;
      val_n[d]     = 0;
      n_pops[d]    = 0;
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      pend1[d].delete();
      pend2[d].delete();
      q1[d].delete();
      q2[d].delete();
      exp_q[d].delete();
      exp_runs[d] = 0;
      exp_err[d]  = 1'b0;
    end
  endtask

  function automatic bit busy(int d);
    return (pend1[d].size() + pend2[d].size() + q1[d].size() +
            q2[d].size() + exp_q[d].size()) != 0;
  endfunction

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (stall_pct == 0) begin
        while (pend1[d].size() > 0) q1[d].push_back(pend1[d].pop_front());
        while (pend2[d].size() > 0) q2[d].push_back(pend2[d].pop_front());
      end else begin
        if (pend1[d].size() > 0 && $urandom_range(99) >= stall_pct)
          q1[d].push_back(pend1[d].pop_front());
        if (pend2[d].size() > 0 && $urandom_range(99) >= stall_pct)
          q2[d].push_back(pend2[d].pop_front());
      end
      e1[d]  = (q1[d].size() == 0);
      e2[d]  = (q2[d].size() == 0);
      h1[d]  = e1[d] ? w_t'($urandom) : q1[d][0];
      h2[d]  = e2[d] ? w_t'($urandom) : q2[d][0];
      rdy[d] = ($urandom_range(99) >= bp_pct);
    end
    #4;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      c1[d]    = r1[d];
      c2[d]    = r2[d];
      s_err[d] = err[d];
      if (c1[d] && e1[d]) chk("rd1_on_empty", 1, 0);
      if (c2[d] && e2[d]) chk("rd2_on_empty", 1, 0);
      if (c1[d] || c2[d]) begin
        n_pops[d] += int'(c1[d]) + int'(c2[d]);
        if (first_rd[d] < 0) first_rd[d] = cyc;
      end
      if (d == 0 && (c1[0] || c2[0]))
        src_q.push_back(int'(c1[0]) + 2 * int'(c2[0]));
      if (vld[d]) begin
        if (first_val[d] < 0) first_val[d] = cyc;
        last_val[d] = cyc;
        val_n[d]++;
      end
      if (vld[d] && rdy[d]) begin
        if (exp_q[d].size() == 0) chk("extra_out", 1, 0);
        else chk(d ? "dsc_data" : "asc_data", int'(dat[d]),
                 int'(exp_q[d].pop_front()));
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (c1[d] && q1[d].size() > 0) void'(q1[d].pop_front());
      if (c2[d] && q2[d].size() > 0) void'(q2[d].pop_front());
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((busy(0) || busy(1)) && n < budget) begin
      step();
      n++;
    end
    if (busy(0) || busy(1)) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int   n;
    logic popped2;
    int   want_src [6];

    rst_n = 1'b0;
    clear_model();
    clear_trk();
    for (int d = 0; d < 2; d++) begin
      e1[d]  = 1'b0;
      e2[d]  = 1'b0;
      h1[d]  = w_t'(1);
      h2[d]  = w_t'(2);
      rdy[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", int'(vld[d]), 0);
      chk("rst_cnt", int'(cnt[d]), 0);
      chk("rst_err", int'(err[d]), 0);
      chk("rst_rd", int'(r1[d] | r2[d]), 0);
    end

    ra = '{w_t'(1), w_t'(4), w_t'(9)};
    rb = '{w_t'(2), w_t'(3), w_t'(10)};
    add_pair(0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("no_pop_after_rst", int'(r1[0] | r2[0]), 0);
    drain(100);
    chk("t1_latency", first_val[0] - first_rd[0], 1);
    chk("t1_valid_cycles", val_n[0], 7);
    chk("t1_consecutive", last_val[0] - first_val[0], 6);
    chk("t1_cnt", int'(cnt[0]), exp_runs[0] % 16);
    chk("t1_err", int'(err[0]), int'(exp_err[0]));

    src_q.delete();
    ra = '{w_t'(5), w_t'(5)};
    rb = '{w_t'(5), w_t'(7), w_t'(8)};
    add_pair(0);
    drain(100);
    want_src = '{1, 1, 2, 2, 2, 3};
    chk("t2_pop_count", src_q.size(), 6);
    foreach (want_src[k])
      if (k < src_q.size()) chk("t2_src", src_q[k], want_src[k]);

    ra = '{w_t'(9), w_t'(3)};
    rb = '{w_t'(8)};
    add_pair(1);
    ra.delete();
    rb.delete();
    add_pair(1);
    drain(100);
    chk("t3_cnt", int'(cnt[1]), 2);

    bp_pct = 100;
    ra = '{w_t'(1), w_t'(3), w_t'(5), w_t'(7), w_t'(9)};
    rb = '{w_t'(2), w_t'(4), w_t'(6), w_t'(8), w_t'(10)};
    add_pair(0);
    clear_trk();
    repeat (12) step();
    chk("t4_pops", n_pops[0], 4);
    chk("t4_rd_idle", int'(c1[0] | c2[0]), 0);
    bp_pct = 0;
    drain(200);
    chk("t4_cnt", int'(cnt[0]), exp_runs[0] % 16);

    stall_pct = 25;
    bp_pct    = 30;
    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < 2; d++) begin
        rand_runs(d == 1);
        add_pair(d);
      end
    end
    drain(20000);
    stall_pct = 0;
    bp_pct    = 0;
    for (int d = 0; d < 2; d++) begin
      chk("t5_cnt", int'(cnt[d]), exp_runs[d] % 16);
      chk("t5_err", int'(err[d]), int'(exp_err[d]));
    end

    ra = '{w_t'(4), w_t'(2)};
    rb.delete();
    add_pair(0);
    popped2 = 1'b0;
    n = 0;
    while (busy(0) && n < 100) begin
      step();
      chk("t6_err_timing", int'(s_err[0]), int'(popped2));
      if (c1[0] && h1[0] == w_t'(2)) popped2 = 1'b1;
      n++;
    end
    if (busy(0)) chk("t6_timeout", 1, 0);
    repeat (3) step();
    chk("t6_sticky", int'(err[0]), int'(exp_err[0]));

    ra = '{w_t'(1), w_t'(2), w_t'(3)};
    rb = '{w_t'(4), w_t'(5), w_t'(6)};
    add_pair(0);
    n = 0;
    while (exp_q[0].size() > 4 && n < 50) begin
      step();
      n++;
    end
    chk("t7_pre_valid", int'(vld[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", int'(vld[0]), 0);
    chk("t7_cnt", int'(cnt[0]), 0);
    chk("t7_err", int'(err[0]), 0);
    chk("t7_rd", int'(r1[0] | r2[0]), 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    ra = '{w_t'(2), w_t'(6)};
    rb = '{w_t'(3), w_t'(4)};
    add_pair(0);
    drain(100);
    chk("t7_post_cnt", int'(cnt[0]), 1);
    chk("t7_post_err", int'(err[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/merger_stream.md
Name: merger_stream

Overview:
- Parametrised successor to the two-way run merger.
- Pops two show-ahead upstream FIFOs, each carrying sorted runs terminated by a 0 sentinel word.
- Emits one merged run per input run pair, followed by a single 0, into an internal output FIFO drained via valid/ready.
- Adds over the previous generation: width/depth parameters, ascending or descending mode, stable tie-break, run counting, order-violation detection and async reset.

Parameters:
- DATA_W, 32: data word width; value 0 is reserved as the run terminator.
- OUT_DEPTH, 8: internal output FIFO depth, power of 2, minimum 2.
- DESCENDING, 0: 0 = runs ascending, output smallest first; 1 = runs descending, output largest first.
- CNT_W, 16: width of the run counter.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_fifo_1  in  DATA_W  head word of upstream FIFO 1 (show-ahead).
- i_fifo_1_empty  in  1  upstream FIFO 1 empty.
- o_fifo_1_read  out  1  pop FIFO 1 this cycle (combinational).
- i_fifo_2 / i_fifo_2_empty / o_fifo_2_read: same for channel 2.
- o_data  out  DATA_W  output FIFO head.
- o_valid  out  1  output FIFO not empty.
- i_out_ready  in  1  downstream accepts o_data when o_valid & i_out_ready.
- o_run_cnt  out  CNT_W  terminators written since reset; wraps modulo 2^CNT_W.
- o_err_order  out  1  sticky: an input run violated the sort order.

Behaviour:
- Reset (i_rst_n low, async): output FIFO emptied, o_valid=0, o_run_cnt=0, o_err_order=0, FSM=MERGE, both last-value registers cleared. o_fifo_*_read is 0 while reset is asserted.
- A decision may fire only in a cycle where the output FIFO is not full (can_wr).
- FIFO full is evaluated including a same-cycle output pop, so full with a pop counts as not full.
- At most one output FIFO write per cycle. At most one pop per channel per cycle.
- "Precedes" means <= when DESCENDING=0 and >= when DESCENDING=1.
- FSM MERGE, A=i_fifo_1, B=i_fifo_2; both heads must be non-empty, otherwise stall with no pop:
  - A!=0, B!=0: pop the head that precedes the other and write it. Ties go to channel 1.
  - A==0, B!=0: pop B, write B, go to DRAIN_2. The A sentinel is not popped.
  - A!=0, B==0: pop A, write A, go to DRAIN_1.
  - A==0, B==0: pop both, write one 0, o_run_cnt+1, stay in MERGE.
- FSM DRAIN_1 (channel 2 is parked on its sentinel); requires only FIFO 1 non-empty:
  - Head !=0: pop and write it.
  - Head ==0: pop both channels (channel 2 head is known to be 0), write 0, o_run_cnt+1, go to MERGE.
- FSM DRAIN_2: mirror of DRAIN_1.
- Latency: a pop at edge t is visible on o_valid/o_data after edge t+1 if the FIFO was empty. Throughput is 1 word/cycle with i_out_ready held high.
- Output FIFO full and no pop: no decision, no upstream pop, state held.
- Order check, per channel:
  - A last-value register holds the previous non-zero word popped in the current run; it is cleared when that channel's sentinel is popped.
  - If a popped non-zero word does not follow the last value in order (last precedes new fails, with equality allowed), set o_err_order.
  - The offending word is still merged unchanged.
- Empty runs (a sentinel-only input) are legal; two empty runs produce a single 0 output.
- Input words are not registered; o_fifo_*_read depends combinationally on the heads, the empties, FSM state and FIFO full.
- Deassertion of reset is synchronous to i_clk; no pop occurs in the first cycle after deassertion.

Decomposition:
- Shared package: the FSM state encoding (MERGE, DRAIN_1, DRAIN_2) and the sentinel constant ZERO_WORD.
- The ordering function (precedes(a,b,DESCENDING)) is a package function.
- One sub-module: sync_fifo_fwft (DATA_W, OUT_DEPTH; async active-low reset; push/pop/full/empty; show-ahead output), used for the output FIFO.

Test Plan:
- Ascending merge: ch1 = 1,4,9,0; ch2 = 2,3,10,0; ready=1 -> output 1,2,3,4,9,10,0; o_run_cnt=1; o_err_order=0; 7 consecutive o_valid cycles starting 1 cycle after the first pop.
- Tie and drain: ch1 = 5,5,0; ch2 = 5,7,8,0 -> 5(ch1),5(ch1),5(ch2),7,8,0; FSM enters DRAIN_2 after ch1's sentinel is seen.
- Descending mode (DESCENDING=1): ch1 = 9,3,0; ch2 = 8,0; empty run pair ch1 = 0, ch2 = 0 -> 9,8,3,0,0; o_run_cnt=2.
- Backpressure (OUT_DEPTH=4): i_out_ready=0 with 10 words pending -> exactly 4 pops, o_fifo_*_read then 0. Release ready -> full stream in order, no loss or duplicates.
- Order error: ch1 = 4,2,0; ch2 = 0 -> output 4,2,0; o_err_order goes to 1 the cycle after 2 is popped and stays 1 until reset.
- Mid-run reset: assert i_rst_n=0 asynchronously between edges after 3 of 6 words -> o_valid=0 and o_run_cnt=0 immediately. After release, a fresh run pair merges correctly from MERGE.
